gcd_controller: RTL
===================

Name: gcd_controller

Overview:
- Control-path FSM for the 16-bit subtractive GCD datapath; the counterpart that consumes the datapath status flags (gt, lt, eq) and drives its control strobes (lda, ldb, sel1, sel2, sin).
- Sequences operand load, compare, and subtract-and-writeback until the operands are equal.
- Exposes a start/done handshake, a busy flag and an iteration count to the surrounding system.
- Sits beside GCD_data_path in the top-level GCD wrapper.

Parameters:
- CNT_W, 16, width of the iteration counter iter_cnt.
- MAX_ITER, 65535, subtraction limit before the timeout error. Used only with GCD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a GCD computation; sampled only in IDLE.
- gt  input  1  datapath flag: A > B.
- lt  input  1  datapath flag: A < B.
- eq  input  1  datapath flag: A == B.
- lda  output  1  load enable for register A.
- ldb  output  1  load enable for register B.
- sel1  output  1  subtractor minuend mux select: 0 = A, 1 = B.
- sel2  output  1  subtractor subtrahend mux select: 0 = A, 1 = B.
- sin  output  1  load-bus mux select: 0 = subtractor result, 1 = din.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  timeout flag; held until the next start or rst.
- iter_cnt  output  CNT_W  number of subtractions in the current or last run.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Moore FSM. All control outputs decode from the state register only; they are not combinational from gt/lt/eq.
- States and outputs (any strobe not listed is 0):
  - IDLE: all strobes 0.
  - LOAD_A: lda=1, sin=1.
  - LOAD_B: ldb=1, sin=1.
  - COMPARE: all strobes 0; datapath registers settle.
  - SUB_A: lda=1, sel1=0, sel2=1, sin=0 (A <= A-B).
  - SUB_B: ldb=1, sel1=1, sel2=0, sin=0 (B <= B-A).
  - DONE: done=1.
  - ERR: err set, done=1.
- Transitions:
  - IDLE -> LOAD_A when start=1; on this edge iter_cnt and err clear.
  - LOAD_A -> LOAD_B -> COMPARE, unconditionally.
  - COMPARE, decided with priority eq > gt > lt:
    - eq -> DONE.
    - gt -> SUB_A.
    - lt -> SUB_B.
    - no flag set -> stay in COMPARE.
  - SUB_A and SUB_B -> COMPARE; iter_cnt increments on entry to SUB_A/SUB_B.
  - DONE -> IDLE.
  - ERR -> IDLE.
- Upstream contract: din carries operand A while lda=1 in LOAD_A, and operand B while ldb=1 in LOAD_B.
- Latency:
  - start sampled at edge k -> LOAD_A in cycle k+1 -> DONE in cycle k+4+2N, where N is the number of subtractions.
  - busy is high from cycle k+1 through the DONE cycle.
- start is ignored while busy; start held high in IDLE re-triggers the next cycle after DONE -> IDLE.
- iter_cnt saturates at all-ones and never wraps; it holds its value in IDLE.
- rst in any state: next state IDLE; all strobes, busy, done and err 0; iter_cnt 0. Reset wins over start.
- Zero operand (one operand 0, the other non-zero): never converges. This is the timeout case.

Optional Feature:
- Macro GCD_TIMEOUT_EN.
- Defined: in COMPARE, if iter_cnt == MAX_ITER and eq=0, go to ERR instead of subtracting. ERR pulses done and sets err, which holds until the next start or rst.
- Undefined: no ERR state; err tied 0; a zero operand loops until rst.

Test Plan:
- A=7, B=7, start pulse at edge k -> done=1 in cycle k+4, iter_cnt=0, err=0, no SUB state visited.
- A=12, B=8 -> SUB_A then SUB_B; done in cycle k+8; iter_cnt=2; datapath holds A=B=4.
- A=13, B=5 -> five subtractions in order SUB_A, SUB_A, SUB_B, SUB_A, SUB_B; done at k+14; iter_cnt=5; result 1.
- GCD_TIMEOUT_EN with MAX_ITER=16, A=9, B=0 -> 16 SUB_A states, then ERR; done=1 and err=1 at k+36; err stays 1 in IDLE until the next start.
- rst asserted during SUB_A of the A=12, B=8 run -> next cycle IDLE with all outputs 0; new start with A=6, B=4 completes normally with iter_cnt=2.
- start re-pulsed while busy in the A=12, B=8 run -> ignored; exactly one done pulse; a second start after DONE begins a fresh run.

Source files
------------

// File: rtl/gcd_controller.sv
// Moore control FSM for the 16-bit subtractive GCD datapath (load, compare, subtract).
// Define GCD_TIMEOUT_EN to add the MAX_ITER timeout and ERR state.
module gcd_controller #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             sel1,
    output logic             sel2,
    output logic             sin,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StCompare,
        StSubA,
        StSubB,
`ifdef GCD_TIMEOUT_EN
        StDone,
        StErr
`else
        StDone
`endif
    } state_e;

`ifdef GCD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MaxIterC = CNT_W'(MAX_ITER);
`endif

    state_e           r_state;
    state_e           w_next;
    logic [6:0]       w_out;
    logic             r_lda, r_ldb, r_sel1, r_sel2, r_sin, r_busy, r_done, r_err;
    logic [CNT_W-1:0] r_iter;
    logic             w_accept;
    logic             w_enter_sub;

    assign w_accept    = (r_state == StIdle) && start;
    assign w_enter_sub = (w_next == StSubA) || (w_next == StSubB);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:    w_next = start ? StLoadA : StIdle;
            StLoadA:   w_next = StLoadB;
            StLoadB:   w_next = StCompare;
            StCompare: begin
                if (eq) begin
                    w_next = StDone;
`ifdef GCD_TIMEOUT_EN
                end else if (r_iter == MaxIterC) begin
                    w_next = StErr;
`endif
                end else if (gt) begin
                    w_next = StSubA;
                end else if (lt) begin
                    w_next = StSubB;
                end else begin
                    w_next = StCompare;
                end
            end
            StSubA:    w_next = StCompare;
            StSubB:    w_next = StCompare;
            StDone:    w_next = StIdle;
`ifdef GCD_TIMEOUT_EN
            StErr:     w_next = StIdle;
`endif
            default:   w_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it: {lda,ldb,sel1,sel2,sin,busy,done}
    always_comb begin
        w_out = 7'b0000000;
        unique case (w_next)
            StIdle:    w_out = 7'b0000000;
            StLoadA:   w_out = 7'b1000110;
            StLoadB:   w_out = 7'b0100110;
            StCompare: w_out = 7'b0000010;
            StSubA:    w_out = 7'b1001010;
            StSubB:    w_out = 7'b0110010;
            StDone:    w_out = 7'b0000011;
`ifdef GCD_TIMEOUT_EN
            StErr:     w_out = 7'b0000011;
`endif
            default:   w_out = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_lda   <= 1'b0;
            r_ldb   <= 1'b0;
            r_sel1  <= 1'b0;
            r_sel2  <= 1'b0;
            r_sin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_iter  <= '0;
        end else begin
            r_state <= w_next;
            {r_lda, r_ldb, r_sel1, r_sel2, r_sin, r_busy, r_done} <= w_out;
            if (w_accept) begin
                r_iter <= '0;
                r_err  <= 1'b0;
            end else begin
                if (w_enter_sub && (r_iter != '1)) begin
                    r_iter <= r_iter + 1'b1;
                end
`ifdef GCD_TIMEOUT_EN
                if (w_next == StErr) begin
                    r_err <= 1'b1;
                end
`endif
            end
        end
    end

    assign lda      = r_lda;
    assign ldb      = r_ldb;
    assign sel1     = r_sel1;
    assign sel2     = r_sel2;
    assign sin      = r_sin;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign iter_cnt = r_iter;

endmodule
